// File: rtl/layer_seq_pkg.sv
// ============================================================================
// layer_seq_pkg : shared types, widths and helpers for the layer sequencer
// Revision      : 1.0
// ============================================================================
`default_nettype none

package layer_seq_pkg;

    localparam int Q_W             = 16;
    localparam int SIG_W           = 8;
    localparam int DEF_NUM_INPUTS  = 784;
    localparam int DEF_NUM_NEURONS = 10;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CLEAR    = 3'd1,
        STREAM   = 3'd2,
        DRAIN    = 3'd3,
        WAIT_SIG = 3'd4,
        DONE     = 3'd5
    } state_t;

    // Address width that never collapses to zero bits for single-entry ROMs.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int DEF_PIX_AW = addr_w(DEF_NUM_INPUTS);
    localparam int DEF_W_AW   = addr_w(DEF_NUM_INPUTS * DEF_NUM_NEURONS);
    localparam int DEF_N_AW   = addr_w(DEF_NUM_NEURONS);

endpackage

`default_nettype wire

// File: rtl/argmax_tracker.sv
// ============================================================================
// argmax_tracker : running maximum of neuron outputs, lowest index wins ties
// Revision       : 1.0
// ============================================================================
`default_nettype none

module argmax_tracker #(
    parameter int IDX_W = 4,
    parameter int VAL_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_first,
    input  logic             valid,
    input  logic [IDX_W-1:0] idx,
    input  logic [VAL_W-1:0] value,
    output logic [IDX_W-1:0] class_idx,
    output logic [VAL_W-1:0] class_score
);

    logic [IDX_W-1:0] r_idx;
    logic [VAL_W-1:0] r_score;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_idx   <= '0;
            r_score <= '0;
        end else if (valid && (load_first || (value > r_score))) begin
            r_idx   <= idx;
            r_score <= value;
        end
    end

    assign class_idx   = r_idx;
    assign class_score = r_score;

endmodule

`default_nettype wire

// File: rtl/layer_sequencer.sv
// ============================================================================
// layer_sequencer : steps one shared neuron through every output of a layer
// Revision        : 1.0
// ============================================================================
`default_nettype none

module layer_sequencer
    import layer_seq_pkg::*;
#(
    parameter  int NUM_INPUTS  = DEF_NUM_INPUTS,
    parameter  int NUM_NEURONS = DEF_NUM_NEURONS,
    parameter  int WD_TIMEOUT  = 8,
    localparam int PIX_AW      = addr_w(NUM_INPUTS),
    localparam int W_AW        = addr_w(NUM_INPUTS * NUM_NEURONS),
    localparam int N_AW        = addr_w(NUM_NEURONS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [PIX_AW-1:0] pix_addr,
    input  logic [Q_W-1:0]    pix_data,
    output logic [W_AW-1:0]   w_addr,
    input  logic [Q_W-1:0]    w_data,
    output logic [N_AW-1:0]   b_addr,
    input  logic [Q_W-1:0]    b_data,
    output logic              nrn_reset,
    output logic              nrn_inp_ready,
    output logic [Q_W-1:0]    nrn_inp_data,
    output logic [Q_W-1:0]    nrn_weight,
    output logic [Q_W-1:0]    nrn_bias,
    input  logic [SIG_W-1:0]  nrn_sigmoid_out,
    input  logic              nrn_sigmoid_ready,
    output logic              res_wr_en,
    output logic [N_AW-1:0]   res_wr_addr,
    output logic [SIG_W-1:0]  res_wr_data,
    output logic [N_AW-1:0]   class_idx,
    output logic [SIG_W-1:0]  class_score
);

    localparam int WD_W = addr_w(WD_TIMEOUT + 1);

    state_t           r_state;
    state_t           w_next;
    logic [N_AW-1:0]  r_j;
    logic [PIX_AW-1:0] r_i;
    logic [W_AW-1:0]  r_w;
    logic [W_AW-1:0]  r_wbase;
    logic [WD_W-1:0]  r_wd;
    logic             r_issue_d;
    logic             r_err;
    logic             r_first;
    logic [Q_W-1:0]   r_bias;

    logic w_last_pix;
    logic w_last_nrn;
    logic w_sig_hit;
    logic w_timeout;
    logic w_nrn_end;

    assign w_last_pix = (r_i == PIX_AW'(NUM_INPUTS - 1));
    assign w_last_nrn = (r_j == N_AW'(NUM_NEURONS - 1));
    assign w_sig_hit  = (r_state == WAIT_SIG) && nrn_sigmoid_ready;
    assign w_timeout  = (r_state == WAIT_SIG) && !nrn_sigmoid_ready
                        && (r_wd == WD_W'(WD_TIMEOUT - 1));
    assign w_nrn_end  = w_sig_hit || w_timeout;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (start) w_next = CLEAR;
            CLEAR:    w_next = STREAM;
            STREAM:   if (w_last_pix) w_next = DRAIN;
            DRAIN:    w_next = WAIT_SIG;
            WAIT_SIG: if (w_nrn_end) w_next = w_last_nrn ? DONE : CLEAR;
            DONE:     w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        nrn_reset = 1'b0;
        case (r_state)
            IDLE:                    nrn_reset = 1'b1;
            CLEAR:    begin busy = 1'b1; nrn_reset = 1'b1; end
            STREAM,
            DRAIN,
            WAIT_SIG:                busy = 1'b1;
            DONE:     begin done = 1'b1; nrn_reset = 1'b1; end
            default:                 nrn_reset = 1'b1;
        endcase
    end

    // Weight address walks from a running base so no j*NUM_INPUTS product is needed.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_j       <= '0;
            r_i       <= '0;
            r_w       <= '0;
            r_wbase   <= '0;
            r_wd      <= '0;
            r_issue_d <= 1'b0;
            r_err     <= 1'b0;
            r_first   <= 1'b0;
            r_bias    <= '0;
        end else begin
            r_issue_d <= (r_state == STREAM);
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_j     <= '0;
                        r_wbase <= '0;
                        r_err   <= 1'b0;
                        r_first <= 1'b1;
                    end
                end
                CLEAR: begin
                    r_i <= '0;
                    r_w <= r_wbase;
                end
                STREAM: begin
                    if (r_i == '0) r_bias <= b_data;
                    if (!w_last_pix) begin
                        r_i <= r_i + 1'b1;
                        r_w <= r_w + 1'b1;
                    end
                end
                DRAIN: r_wd <= '0;
                WAIT_SIG: begin
                    r_wd <= r_wd + 1'b1;
                    if (w_sig_hit) r_first <= 1'b0;
                    if (w_timeout) r_err <= 1'b1;
                    if (w_nrn_end && !w_last_nrn) begin
                        r_j     <= r_j + 1'b1;
                        r_wbase <= r_wbase + W_AW'(NUM_INPUTS);
                    end
                end
                default: ;
            endcase
        end
    end

    assign pix_addr      = r_i;
    assign w_addr        = r_w;
    assign b_addr        = r_j;
    assign nrn_inp_ready = r_issue_d;
    assign nrn_inp_data  = pix_data;
    assign nrn_weight    = w_data;
    assign nrn_bias      = r_bias;
    assign err           = r_err;
    assign res_wr_en     = w_sig_hit;
    assign res_wr_addr   = r_j;
    assign res_wr_data   = w_sig_hit ? nrn_sigmoid_out : '0;

    // First real write of a pass loads unconditionally, even if neuron 0 timed out.
    argmax_tracker #(
        .IDX_W (N_AW),
        .VAL_W (SIG_W)
    ) u_argmax (
        .clk         (clk),
        .reset       (reset),
        .load_first  (r_first),
        .valid       (w_sig_hit),
        .idx         (r_j),
        .value       (nrn_sigmoid_out),
        .class_idx   (class_idx),
        .class_score (class_score)
    );

endmodule

`default_nettype wire

// File: tb/tb_layer_sequencer.sv
// ============================================================================
// tb_layer_sequencer : scoreboard bench with ROM and neuron stubs
// Revision           : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_layer_sequencer;

    localparam int NI  = 784;
    localparam int NN  = 10;
    localparam int PER = NI + 5;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, err;
    logic [9:0]  pix_addr;
    logic [15:0] pix_data;
    logic [12:0] w_addr;
    logic [15:0] w_data;
    logic [3:0]  b_addr;
    logic [15:0] b_data;
    logic        nrn_reset, nrn_inp_ready;
    logic [15:0] nrn_inp_data, nrn_weight, nrn_bias;
    logic [7:0]  nrn_sigmoid_out;
    logic        nrn_sigmoid_ready;
    logic        res_wr_en;
    logic [3:0]  res_wr_addr;
    logic [7:0]  res_wr_data;
    logic [3:0]  class_idx;
    logic [7:0]  class_score;

    layer_sequencer dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .busy              (busy),
        .done              (done),
        .err               (err),
        .pix_addr          (pix_addr),
        .pix_data          (pix_data),
        .w_addr            (w_addr),
        .w_data            (w_data),
        .b_addr            (b_addr),
        .b_data            (b_data),
        .nrn_reset         (nrn_reset),
        .nrn_inp_ready     (nrn_inp_ready),
        .nrn_inp_data      (nrn_inp_data),
        .nrn_weight        (nrn_weight),
        .nrn_bias          (nrn_bias),
        .nrn_sigmoid_out   (nrn_sigmoid_out),
        .nrn_sigmoid_ready (nrn_sigmoid_ready),
        .res_wr_en         (res_wr_en),
        .res_wr_addr       (res_wr_addr),
        .res_wr_data       (res_wr_data),
        .class_idx         (class_idx),
        .class_score       (class_score)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int t0    = 0;
    bit in_pass = 1'b0;
    bit stream_chk = 1'b0;
    bit withhold = 1'b0;
    int rom_mode = 0;

    typedef struct { int addr; int data; } wr_t;
    typedef struct { int cyc; int idx; int score; int err; } dn_t;
    wr_t exp_wr[$];
    dn_t exp_done[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ROM contents: 0 = bias ramp, 1 = all zero, 2 = single pixel/weight pairing
    function automatic logic [15:0] pix_val(input int a);
        return (rom_mode == 2 && a == 5) ? 16'h0100 : 16'h0000;
    endfunction
    function automatic logic [15:0] w_val(input int a);
        return (rom_mode == 2 && (a % NI) == 5) ? 16'((a / NI) * 128) : 16'h0000;
    endfunction
    function automatic logic [15:0] bias_val(input int j);
        return (rom_mode == 0) ? 16'(j * 256) : 16'h0000;
    endfunction

    always @(posedge clk) begin
        pix_data <= pix_val(int'(pix_addr));
        w_data   <= w_val(int'(w_addr));
        b_data   <= bias_val(int'(b_addr));
    end

    // Neuron stub: MAC on inp_ready, result strobe 3 cycles after the last pair.
    logic signed [31:0] stub_acc;
    int                 stub_cnt;
    int                 stub_fire;
    logic [15:0]        stub_x;
    always @(posedge clk) begin
        if (nrn_reset) begin
            stub_acc  <= 0;
            stub_cnt  <= 0;
            stub_fire <= 0;
        end else if (nrn_inp_ready) begin
            stub_acc <= stub_acc + (($signed({{16{nrn_inp_data[15]}}, nrn_inp_data})
                                    * $signed({{16{nrn_weight[15]}}, nrn_weight})) >>> 8);
            stub_cnt <= stub_cnt + 1;
            if (stub_cnt == NI - 1) stub_fire <= 3;
        end else if (stub_fire > 0) begin
            stub_fire <= stub_fire - 1;
        end
    end
    assign stub_x            = stub_acc[15:0] + nrn_bias;
    assign nrn_sigmoid_out   = {~stub_x[15], stub_x[14:8]};
    assign nrn_sigmoid_ready = (stub_fire == 1) && !(withhold && b_addr == 4'd3);

    wr_t wm;
    always @(negedge clk) begin
        if (res_wr_en) begin
            if (exp_wr.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                wm = exp_wr.pop_front();
                check("wr_addr", res_wr_addr, wm.addr);
                check("wr_data", res_wr_data, wm.data);
            end
        end
    end

    dn_t dm;
    always @(negedge clk) begin
        if (done) begin
            if (exp_done.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                dm = exp_done.pop_front();
                check("done_cycle", cyc - t0, dm.cyc);
                check("class_idx", class_idx, dm.idx);
                check("class_score", class_score, dm.score);
                check("err_at_done", err, dm.err);
                check("writes_drained_at_done", exp_wr.size(), 0);
            end
        end
    end

    int sm_n, sm_j, sm_p, s_err, s_rdy;
    always @(negedge clk) begin
        if (stream_chk && in_pass) begin
            sm_n = cyc - t0;
            if (sm_n >= 1 && sm_n <= NN * PER) begin
                sm_j = (sm_n - 1) / PER;
                sm_p = (sm_n - 1) % PER;
                if (sm_p == 0) begin
                    s_err = 0;
                    s_rdy = 0;
                end
                if (nrn_reset !== (sm_p == 0)) s_err++;
                if (busy !== 1'b1) s_err++;
                if (nrn_inp_ready === 1'b1) s_rdy++;
                if (nrn_inp_ready !== (sm_p >= 2 && sm_p <= NI + 1)) s_err++;
                if (sm_p >= 1 && sm_p <= NI) begin
                    if (pix_addr !== 10'(sm_p - 1) || w_addr !== 13'(sm_j * NI + sm_p - 1)) s_err++;
                end
                if (sm_p >= 2 && nrn_bias !== bias_val(sm_j)) s_err++;
                if (sm_p == PER - 1) begin
                    check($sformatf("stream_ready_count_n%0d", sm_j), s_rdy, NI);
                    check($sformatf("stream_errors_n%0d", sm_j), s_err, 0);
                end
            end
        end
    end

    task automatic push_pass(input int skip, input int dcyc, input int didx,
                             input int dscore, input int derr);
        for (int j = 0; j < NN; j++) begin
            if (j != skip) begin
                case (rom_mode)
                    0:       exp_wr.push_back(wr_t'{j, 128 + j});
                    1:       exp_wr.push_back(wr_t'{j, 128});
                    default: exp_wr.push_back(wr_t'{j, 128 + j / 2});
                endcase
            end
        end
        exp_done.push_back(dn_t'{dcyc, didx, dscore, derr});
    endtask

    // Called at a negedge; that cycle becomes cycle 0 of the pass.
    task automatic start_pass();
        start   = 1'b1;
        t0      = cyc;
        in_pass = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic run_pass(input bit pulse, input int err_cyc);
        int n;
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 9000 && !seen; k++) begin
            @(negedge clk);
            n = cyc - t0;
            start = pulse && (n == 100 || n == 5000);
            if (err_cyc > 0 && n == err_cyc - 1) check("err_before_timeout", err, 0);
            if (err_cyc > 0 && n == err_cyc) check("err_after_timeout", err, 1);
            if (done === 1'b1) seen = 1'b1;
        end
        start = 1'b0;
        if (!seen) check("done_timeout", 0, 1);
        in_pass = 1'b0;
        @(negedge clk);
        check("busy_after_done", busy, 0);
        check("done_single_pulse", done, 0);
    endtask

    initial begin
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_nrn_reset", nrn_reset, 1);
        check("rst_inp_ready", nrn_inp_ready, 0);
        check("rst_wr_en", res_wr_en, 0);
        check("rst_class_idx", class_idx, 0);
        check("rst_class_score", class_score, 0);
        check("rst_pix_addr", pix_addr, 0);
        check("rst_w_addr", w_addr, 0);
        check("rst_nrn_bias", nrn_bias, 0);
        reset = 1'b1;
        @(negedge clk);

        // Bias ramp with stray start pulses while busy
        rom_mode = 0;
        stream_chk = 1'b1;
        push_pass(-1, 7891, 9, 137, 0);
        start_pass();
        run_pass(1'b1, 0);

        // Watchdog on neuron 3
        stream_chk = 1'b0;
        withhold = 1'b1;
        push_pass(3, 7896, 9, 137, 1);
        start_pass();
        run_pass(1'b0, 3162);
        withhold = 1'b0;
        check("err_sticky_idle", err, 1);

        // All-zero ROMs: every output ties, lowest index wins
        rom_mode = 1;
        stream_chk = 1'b1;
        push_pass(-1, 7891, 0, 128, 0);
        start_pass();
        check("err_cleared_by_start", err, 0);
        run_pass(1'b0, 0);

        // Pixel/weight pairing: pairs 8 and 9 tie at the top
        rom_mode = 2;
        push_pass(-1, 7891, 8, 132, 0);
        start_pass();
        run_pass(1'b0, 0);

        // Reset low for one cycle mid-pass
        rom_mode = 0;
        stream_chk = 1'b0;
        exp_wr.push_back(wr_t'{0, 128});
        start_pass();
        for (int k = 0; k < 1100 && (cyc - t0) < 1000; k++) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("midrst_busy", busy, 0);
        check("midrst_nrn_reset", nrn_reset, 1);
        check("midrst_done", done, 0);
        check("midrst_inp_ready", nrn_inp_ready, 0);
        in_pass = 1'b0;
        repeat (20) @(negedge clk);
        check("midrst_busy_later", busy, 0);
        check("midrst_writes_drained", exp_wr.size(), 0);

        stream_chk = 1'b1;
        push_pass(-1, 7891, 9, 137, 0);
        start_pass();
        run_pass(1'b0, 0);

        check("final_writes_pending", exp_wr.size(), 0);
        check("final_done_pending", exp_done.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
